// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: loader states and frame constants shared by the boot loader files
package boot_pkg;
  typedef enum logic [2:0] {WAIT_SYNC, LEN_HI, LEN_LO, DATA, CHECK, RUN, ERR} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int HDR_BYTES = 3;
endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte-stream input and instruction-memory write port of the loader
// master: loader side (consumes rx bytes, drives im_* writes); slave: the surrounding system
interface imem_boot_loader_if #(parameter int ADDR_W = 10);
  logic rx_valid;
  logic [7:0] rx_data;
  logic rx_ready;
  logic im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0] im_wdata;
  modport master(input rx_valid, rx_data, output rx_ready, im_we, im_addr, im_wdata);
  modport slave(output rx_valid, rx_data, input rx_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// byte_packer: assembles big-endian 32-bit words from a byte stream
// clock/reset: clock and async active-high reset; clr: sync clear of shift state;
// en: byte accepted on din; word: assembled word including din; last: din completes the word
module byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        last
);
  logic [23:0] sr_q, sr_d;
  logic [1:0] idx_q, idx_d;
  always_comb begin
    sr_d = clr ? '0 : en ? {sr_q[15:0], din} : sr_q;
    idx_d = clr ? '0 : en ? idx_q + 2'd1 : idx_q;
  end
  assign word = {sr_q, din};
  assign last = en && idx_q == 2'd3;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sr_q <= '0;
      idx_q <= '0;
    end else begin
      sr_q <= sr_d;
      idx_q <= idx_d;
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a checksummed program image into instruction memory, then releases the CPU
// clock/reset: clock and async active-high reset; bus: rx byte stream in, im_* write port out;
// reload: re-enter loading from RUN/ERR; cpu_resetn: CPU reset release; busy/done/err: status
module imem_boot_loader import boot_pkg::*; #(
  parameter int ADDR_W = 10,
  parameter logic [7:0] SYNC = SYNC_BYTE
) (
  input  logic clock,
  input  logic reset,
  imem_boot_loader_if.master bus,
  input  logic reload,
  output logic cpu_resetn,
  output logic busy,
  output logic done,
  output logic err
);
  state_t state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [7:0] chk_q, chk_d;
  logic im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0] im_wdata_q, im_wdata_d;
  logic fire, clr, en, last;
  logic [31:0] word;
  logic [16:0] n, cnt_inc, max_n;
  assign fire = bus.rx_valid && bus.rx_ready;
  assign clr = fire && state_q == LEN_LO;
  assign en = fire && state_q == DATA;
  // word count as it completes during the LEN_LO handshake
  assign n = {1'b0, len_q[15:8], bus.rx_data};
  assign cnt_inc = 17'(cnt_q) + 17'd1;
  assign max_n = 17'd1 << ADDR_W;
  byte_packer u_packer (
    .clock(clock),
    .reset(reset),
    .clr(clr),
    .en(en),
    .din(bus.rx_data),
    .word(word),
    .last(last)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= WAIT_SYNC;
      len_q <= '0;
      cnt_q <= '0;
      chk_q <= '0;
      im_we_q <= 1'b0;
      im_addr_q <= '0;
      im_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      chk_q <= chk_d;
      im_we_q <= im_we_d;
      im_addr_q <= im_addr_d;
      im_wdata_q <= im_wdata_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_SYNC: if (fire && bus.rx_data == SYNC) state_d = LEN_HI;
      LEN_HI:    if (fire) state_d = LEN_LO;
      LEN_LO:    if (fire) state_d = n > max_n ? ERR : n == 17'd0 ? CHECK : DATA;
      DATA:      if (last && cnt_inc == {1'b0, len_q}) state_d = CHECK;
      CHECK:     if (fire) state_d = bus.rx_data == chk_q ? RUN : ERR;
      default:   if (reload) state_d = WAIT_SYNC;
    endcase
  end
  always_comb begin
    len_d = fire && state_q == LEN_HI ? {bus.rx_data, 8'h00} : clr ? n[15:0] : len_q;
    cnt_d = clr ? '0 : last ? cnt_inc[ADDR_W:0] : cnt_q;
    chk_d = clr ? '0 : en ? chk_q ^ bus.rx_data : chk_q;
    im_we_d = last;
    im_addr_d = last ? cnt_q[ADDR_W-1:0] : im_addr_q;
    im_wdata_d = last ? word : im_wdata_q;
  end
  always_comb begin
    bus.rx_ready = state_q != RUN && state_q != ERR;
    busy = state_q inside {LEN_HI, LEN_LO, DATA, CHECK};
    cpu_resetn = state_q == RUN;
    done = state_q == RUN;
    err = state_q == ERR;
  end
  assign bus.im_we = im_we_q;
  assign bus.im_addr = im_addr_q;
  assign bus.im_wdata = im_wdata_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed frames with a write scoreboard and status checks
module tb_imem_boot_loader;
  import boot_pkg::*;
  localparam int AW = 4;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0] d;
  } wr_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic reload = 1'b0;
  logic cpu_resetn, busy, done, err;
  int pass_n = 0;
  int total_n = 0;
  wr_t exp_q[$];
  logic [31:0] words[$];
  imem_boot_loader_if #(.ADDR_W(AW)) bus();
  imem_boot_loader #(.ADDR_W(AW)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .reload(reload),
    .cpu_resetn(cpu_resetn),
    .busy(busy),
    .done(done),
    .err(err)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clock)
    if (bus.im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_n++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.im_addr, bus.im_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.im_addr), 32'(e.a));
        chk("wr_data", bus.im_wdata, e.d);
      end
    end
  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    @(posedge clock);
    #1;
    bus.rx_valid = 1'b0;
  endtask
  task automatic body(input logic [15:0] n, input logic [7:0] c);
    wr_t e;
    send(n[15:8]);
    send(n[7:0]);
    foreach (words[i]) begin
      e.a = AW'(i);
      e.d = words[i];
      exp_q.push_back(e);
      for (int k = 3; k >= 0; k--) send(words[i][8*k +: 8]);
    end
    send(c);
  endtask
  task automatic frame(input logic [15:0] n, input logic [7:0] c);
    send(SYNC_BYTE);
    body(n, c);
  endtask
  function automatic logic [7:0] xsum();
    logic [7:0] x = 8'h00;
    foreach (words[i]) x ^= words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
    return x;
  endfunction
  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clock);
    #1;
    reload = 1'b0;
  endtask
  task automatic status(input string tag, input logic r, input logic d, input logic e, input logic b);
    chk({tag, ".cpu_resetn"}, 32'(cpu_resetn), 32'(r));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask
  task automatic reset_vals(input string tag);
    status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".im_we"}, 32'(bus.im_we), 32'd0);
    chk({tag, ".im_addr"}, 32'(bus.im_addr), 32'd0);
    chk({tag, ".im_wdata"}, bus.im_wdata, 32'd0);
    chk({tag, ".rx_ready"}, 32'(bus.rx_ready), 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    #12;
    reset_vals("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;
    words = '{32'h12345678, 32'h9ABCDEF0};
    frame(16'd2, 8'h00);
    status("t1", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1.rx_ready", 32'(bus.rx_ready), 32'd0);
    pulse_reload();
    status("t1r", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1r.rx_ready", 32'(bus.rx_ready), 32'd1);
    send(8'h00);
    send(8'hFF);
    chk("t2.idle_busy", 32'(busy), 32'd0);
    words = '{32'hDEADBEEF};
    frame(16'd1, 8'h22);
    status("t2", 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_reload();
    words = {};
    frame(16'd0, 8'h00);
    status("t3a", 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_reload();
    frame(16'd0, 8'h01);
    status("t3b", 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_reload();
    send(SYNC_BYTE);
    send(8'h00);
    send(8'h11);
    status("t4a", 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_reload();
    words = {};
    for (int i = 0; i < 16; i++) words.push_back(32'(i + 1) * 32'h01020304);
    frame(16'h0010, xsum());
    status("t4b", 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_reload();
    words = '{32'h01020304};
    frame(16'd1, 8'h05);
    status("t5a", 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_reload();
    chk("t5r.err", 32'(err), 32'd0);
    chk("t5r.rx_ready", 32'(bus.rx_ready), 32'd1);
    send(SYNC_BYTE);
    pulse_reload();
    chk("t5.reload_ignored_busy", 32'(busy), 32'd1);
    words = '{32'hCAFEF00D};
    body(16'd1, 8'hC9);
    status("t5b", 1'b1, 1'b1, 1'b0, 1'b0);
    bus.rx_valid = 1'b1;
    bus.rx_data = SYNC_BYTE;
    repeat (3) @(posedge clock);
    #1;
    chk("t6.run_holds", 32'(done), 32'd1);
    bus.rx_valid = 1'b0;
    pulse_reload();
    chk("t6.reload_cpu_resetn", 32'(cpu_resetn), 32'd0);
    send(SYNC_BYTE);
    send(8'h00);
    send(8'h02);
    exp_q.push_back('{a: AW'(0), d: 32'h11223344});
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h55);
    send(8'h66);
    chk("t6.busy_mid", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    reset_vals("t6.reset");
    reset = 1'b0;
    @(posedge clock);
    #1;
    words = '{32'h0BADC0DE};
    frame(16'd1, 8'hB8);
    status("t6b", 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
